// File: rtl/spi_adc_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_adc_responder_pkg: shared SPI mode, width and state definitions   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_adc_responder_pkg;

    localparam int SPI_CPOL          = 0;
    localparam int SPI_CPHA          = 1;
    localparam int DEFAULT_WORD_BITS = 16;
    localparam int MIN_SYNC_STAGES   = 2;

    localparam logic [DEFAULT_WORD_BITS-1:0] DEFAULT_RESP_IDLE = 16'h0000;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_input_sync: N-stage synchronizer with rise/fall pulse outputs     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_input_sync
    import spi_adc_responder_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    localparam int N_STAGES = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [N_STAGES-1:0] chain;
    logic                hist;

    // Chain and history clear to 0: a CS_N held low through reset release
    // then never looks like a falling edge, so a frame needs CS seen high first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[N_STAGES-2:0], din};
            hist  <= chain[N_STAGES-1];
        end
    end

    assign sync_out = chain[N_STAGES-1];
    assign rise     = sync_out & ~hist;
    assign fall     = ~sync_out & hist;

endmodule
`default_nettype wire

// File: rtl/spi_adc_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_adc_responder: SPI mode-1 responder emulating the ADC far end     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_adc_responder
    import spi_adc_responder_pkg::*;
#(
    parameter int                   WORD_BITS   = DEFAULT_WORD_BITS,
    parameter logic [WORD_BITS-1:0] RESP_IDLE   = WORD_BITS'(DEFAULT_RESP_IDLE),
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                 system_clock,
    input  logic                 reset,
    input  logic                 spi_cs_n,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic [WORD_BITS-1:0] tx_word,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_word,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 busy,
    output logic [7:0]           bit_count
);

    localparam logic [7:0] WORD_CNT       = 8'(WORD_BITS);
    localparam bit         SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_sync;
    logic cs_level_unused, sclk_level_unused, mosi_rise_unused, mosi_fall_unused;

    spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk      (system_clock),
        .rst      (reset),
        .din      (spi_cs_n),
        .sync_out (cs_level_unused),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (system_clock),
        .rst      (reset),
        .din      (spi_sclk),
        .sync_out (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk      (system_clock),
        .rst      (reset),
        .din      (spi_mosi),
        .sync_out (mosi_sync),
        .rise     (mosi_rise_unused),
        .fall     (mosi_fall_unused)
    );

    state_t               state, state_next;
    logic                 pend_full;
    logic [WORD_BITS-1:0] pend_word;
    logic [WORD_BITS-1:0] shift_out;
    logic [WORD_BITS-1:0] shift_in;
    logic [WORD_BITS-1:0] load_word;
    logic                 launch_edge, sample_edge, overrun;

    assign launch_edge = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign overrun     = (bit_count >= WORD_CNT);
    assign load_word   = pend_full ? pend_word : RESP_IDLE;
    assign tx_ready    = ~pend_full;
    assign busy        = (state == ST_ACTIVE);

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MISO is combinational so the MSB appears on the CS-fall detection
    // cycle and the line is released on the CS-rise detection cycle.
    always_comb begin
        state_next  = state;
        spi_miso_oe = 1'b0;
        spi_miso    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next  = ST_ACTIVE;
                    spi_miso_oe = 1'b1;
                    spi_miso    = load_word[WORD_BITS-1];
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else begin
                    spi_miso_oe = 1'b1;
                    spi_miso    = overrun ? 1'b0 : shift_out[WORD_BITS-1];
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            pend_full   <= 1'b0;
            pend_word   <= '0;
            shift_out   <= '0;
            shift_in    <= '0;
            bit_count   <= '0;
            rx_word     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;

            // Accept and consume are exclusive: accept needs an empty buffer.
            if (tx_valid && !pend_full) begin
                pend_full <= 1'b1;
                pend_word <= tx_word;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        shift_out <= load_word;
                        shift_in  <= '0;
                        bit_count <= '0;
                        if (pend_full) begin
                            pend_full <= 1'b0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        if (bit_count == WORD_CNT) begin
                            rx_word  <= shift_in;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        // The MSB is already on the wire, so the first launch edge holds it.
                        if (launch_edge && (bit_count != 8'd0)) begin
                            shift_out <= {shift_out[WORD_BITS-2:0], 1'b0};
                        end
                        if (sample_edge) begin
                            if (!overrun) begin
                                shift_in <= {shift_in[WORD_BITS-2:0], mosi_sync};
                            end
                            bit_count <= sat_inc8(bit_count);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
